// File: rtl/branch_predictor_unit.sv
// Fetch-side branch predictor: direct-mapped BTB plus 2-bit counter table (bimodal or gshare).
// Latency: lookup is combinational (zero cycles); updates commit on the rising clk edge.
// Backpressure: none; a prediction is produced every cycle and every upd_valid is accepted.
module branch_predictor_unit #(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8,
    parameter int GHR_BITS = 6,
    parameter int MODE     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [31:0]         next_pc,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic [31:0]         upd_target,
    input  logic                upd_mispredict,
    output logic [GHR_BITS-1:0] ghr,
    output logic [31:0]         br_count,
    output logic [31:0]         miss_count
);

    localparam int IDX = $clog2(ENTRIES);

    // Prediction tables.
    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [31:0]         tgt_q [ENTRIES];
    logic [1:0]          ctr_q [ENTRIES];

    // Global history and performance counters.
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_nxt;
    logic [31:0]         br_q;
    logic [31:0]         miss_q;

    // Lookup / update index and tag signals.
    logic [IDX-1:0]      ghr_ext;
    logic [IDX-1:0]      bidx;
    logic [IDX-1:0]      pidx;
    logic [TAG_BITS-1:0] pc_tag;
    logic [IDX-1:0]      uidx;
    logic [IDX-1:0]      upidx;
    logic [TAG_BITS-1:0] upd_tag;
    logic [1:0]          ctr_cur;
    logic [1:0]          ctr_nxt;
    logic                upd_pc_unused;

    // Only the index and tag fields of upd_pc matter; fold the rest away.
    assign upd_pc_unused = ^upd_pc;

    // History is zero-extended to the index width before hashing.
    assign ghr_ext = IDX'(ghr_q);

    // Lookup side: BTB index from PC, counter index hashed with history in gshare mode.
    always_comb begin
        bidx   = pc[IDX+1:2];
        pc_tag = pc[2+IDX +: TAG_BITS];
        pidx   = bidx;
        if (MODE != 0) begin
            pidx = bidx ^ ghr_ext;
        end
    end

    // Update side uses the same hashing against the pre-edge history.
    always_comb begin
        uidx    = upd_pc[IDX+1:2];
        upd_tag = upd_pc[2+IDX +: TAG_BITS];
        upidx   = uidx;
        if (MODE != 0) begin
            upidx = uidx ^ ghr_ext;
        end
    end

    // Combinational prediction from pre-update table contents.
    always_comb begin
        pred_hit   = valid_q[bidx] && (tag_q[bidx] == pc_tag);
        pred_taken = pred_hit && ctr_q[pidx][1];
        next_pc    = pred_taken ? tgt_q[bidx] : (pc + 32'd4);
    end

    // Saturating 2-bit counter step for the resolved branch.
    always_comb begin
        ctr_cur = ctr_q[upidx];
        ctr_nxt = ctr_cur;
        if (upd_taken) begin
            if (ctr_cur != 2'b11) begin
                ctr_nxt = ctr_cur + 2'b01;
            end
        end else begin
            if (ctr_cur != 2'b00) begin
                ctr_nxt = ctr_cur - 2'b01;
            end
        end
    end

    // Next history value: shift in the resolved outcome.
    generate
        if (GHR_BITS == 1) begin : g_ghr1
            assign ghr_nxt = upd_taken;
        end else begin : g_ghrn
            assign ghr_nxt = {ghr_q[GHR_BITS-2:0], upd_taken};
        end
    endgenerate

    // Counter table: reset to weakly not-taken, stepped on every resolved branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            ctr_q[upidx] <= ctr_nxt;
        end
    end

    // BTB: allocate/overwrite on taken branches only; not-taken never invalidates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (upd_valid && upd_taken) begin
            valid_q[uidx] <= 1'b1;
            tag_q[uidx]   <= upd_tag;
            tgt_q[uidx]   <= upd_target;
        end
    end

    // Global history register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (upd_valid) begin
            ghr_q <= ghr_nxt;
        end
    end

    // Performance counters, free-running with 32-bit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_q   <= '0;
            miss_q <= '0;
        end else if (upd_valid) begin
            br_q <= br_q + 32'd1;
            if (upd_mispredict) begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign ghr        = ghr_q;
    assign br_count   = br_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Self-checking bench for branch_predictor_unit: bimodal and gshare instances side by side.
// Latency: expects zero-cycle lookup and edge-committed updates.
// Backpressure: none; stimulus is cycle paced.
module tb_branch_predictor_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h100;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispredict = 1'b0;

    logic        b_hit, b_tk, g_hit, g_tk;
    logic [31:0] b_npc, g_npc, b_br, g_br, b_miss, g_miss;
    logic [5:0]  b_ghr, g_ghr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor_unit #(.ENTRIES(64), .TAG_BITS(8), .GHR_BITS(6), .MODE(0)) u_bim (
        .clk(clk), .rst(rst), .pc(pc),
        .pred_hit(b_hit), .pred_taken(b_tk), .next_pc(b_npc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .ghr(b_ghr), .br_count(b_br), .miss_count(b_miss)
    );

    branch_predictor_unit #(.ENTRIES(64), .TAG_BITS(8), .GHR_BITS(6), .MODE(1)) u_gsh (
        .clk(clk), .rst(rst), .pc(pc),
        .pred_hit(g_hit), .pred_taken(g_tk), .next_pc(g_npc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .ghr(g_ghr), .br_count(g_br), .miss_count(g_miss)
    );

    // Reference model state.
    logic        m_valid [64];
    logic [7:0]  m_tag [64];
    logic [31:0] m_tgt [64];
    logic [1:0]  m_ctr [2][64];
    logic [5:0]  m_ghr;
    logic [31:0] m_br, m_miss;

    typedef struct {
        logic        hit;
        logic        tk;
        logic [31:0] npc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] m_pidx(input int mode, input logic [31:0] a);
        logic [5:0] b;
        b = a[7:2];
        return (mode != 0) ? (b ^ m_ghr) : b;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
            m_ctr[0][i] = 2'b01;
            m_ctr[1][i] = 2'b01;
        end
        m_ghr = '0;
        m_br = '0;
        m_miss = '0;
    endtask

    task automatic m_update(input logic [31:0] a, input logic t, input logic [31:0] tg, input logic mis);
        logic [5:0] p;
        logic [5:0] b;
        for (int m = 0; m < 2; m++) begin
            p = m_pidx(m, a);
            if (t && m_ctr[m][p] != 2'b11) m_ctr[m][p] = m_ctr[m][p] + 2'b01;
            else if (!t && m_ctr[m][p] != 2'b00) m_ctr[m][p] = m_ctr[m][p] - 2'b01;
        end
        b = a[7:2];
        if (t) begin
            m_valid[b] = 1'b1;
            m_tag[b] = a[15:8];
            m_tgt[b] = tg;
        end
        m_ghr = {m_ghr[4:0], t};
        m_br = m_br + 32'd1;
        if (mis) m_miss = m_miss + 32'd1;
    endtask

    // Push expected predictions for the current pc: bimodal first, then gshare.
    task automatic push_exp();
        exp_t e;
        logic [5:0] b;
        b = pc[7:2];
        for (int m = 0; m < 2; m++) begin
            e.hit = m_valid[b] && (m_tag[b] == pc[15:8]);
            e.tk  = e.hit && m_ctr[m][m_pidx(m, pc)][1];
            e.npc = e.tk ? m_tgt[b] : pc + 32'd4;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            chk({tag, ".b_hit"}, b_hit, e.hit);
            chk({tag, ".b_tk"},  b_tk,  e.tk);
            chk({tag, ".b_npc"}, b_npc, e.npc);
            e = exp_q.pop_front();
            chk({tag, ".g_hit"}, g_hit, e.hit);
            chk({tag, ".g_tk"},  g_tk,  e.tk);
            chk({tag, ".g_npc"}, g_npc, e.npc);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".b_ghr"},  b_ghr,  m_ghr);
        chk({tag, ".g_ghr"},  g_ghr,  m_ghr);
        chk({tag, ".b_br"},   b_br,   m_br);
        chk({tag, ".g_br"},   g_br,   m_br);
        chk({tag, ".b_miss"}, b_miss, m_miss);
        chk({tag, ".g_miss"}, g_miss, m_miss);
    endtask

    task automatic look(input string tag, input logic [31:0] a);
        pc = a;
        push_exp();
        @(negedge clk);
        drain(tag);
    endtask

    task automatic upd(input logic [31:0] a, input logic t, input logic [31:0] tg, input logic mis);
        @(posedge clk);
        #1;
        upd_valid = 1'b1;
        upd_pc = a;
        upd_taken = t;
        upd_target = tg;
        upd_mispredict = mis;
        @(posedge clk);
        m_update(a, t, tg, mis);
        #1;
        upd_valid = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        m_reset();
        // Reset values while reset is held.
        #2;
        push_exp();
        drain("rst_hold");
        chk_state("rst_hold");
        #10;
        rst = 1'b0;
        look("post_rst", 32'h100);

        // Training toward taken, saturation, then back to not-taken.
        upd(32'h100, 1'b1, 32'h200, 1'b1);
        look("t1", 32'h100);
        upd(32'h100, 1'b1, 32'h200, 1'b0);
        look("t2", 32'h100);
        upd(32'h100, 1'b1, 32'h200, 1'b0);
        look("t3_sat", 32'h100);
        for (int i = 0; i < 3; i++) begin
            upd(32'h100, 1'b0, 32'h0, (i == 1));
            look($sformatf("nt%0d", i), 32'h100);
        end
        chk_state("train");

        // Aliasing: same index, different tag overwrites the entry.
        upd(32'h100, 1'b1, 32'h200, 1'b0);
        upd(32'h100, 1'b1, 32'h200, 1'b0);
        upd(32'h1100, 1'b1, 32'h300, 1'b1);
        look("alias_old", 32'h100);
        look("alias_new", 32'h1100);
        look("wrap", 32'hFFFF_FFFC);

        // History T,N,T; gshare picks a different counter than bimodal.
        do_reset();
        upd(32'h104, 1'b1, 32'h400, 1'b1);
        upd(32'h108, 1'b0, 32'h0, 1'b0);
        upd(32'h100, 1'b1, 32'h200, 1'b1);
        chk("ghr_tnt", g_ghr, 32'h05);
        chk_state("tnt");
        look("gsh_100", 32'h100);
        upd(32'h114, 1'b1, 32'h500, 1'b1);
        upd(32'h114, 1'b1, 32'h500, 1'b0);
        look("gsh_114", 32'h114);
        look("gsh_100b", 32'h100);

        // Same-edge hazard: lookup sees pre-update contents until the edge.
        do_reset();
        upd(32'h100, 1'b1, 32'h200, 1'b0);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        pc = 32'h100;
        upd_valid = 1'b1;
        upd_pc = 32'h100;
        upd_taken = 1'b1;
        upd_target = 32'h200;
        upd_mispredict = 1'b0;
        push_exp();
        @(negedge clk);
        chk("hz_pre_b_tk", b_tk, 1'b0);
        drain("hz_pre");
        @(posedge clk);
        m_update(32'h100, 1'b1, 32'h200, 1'b0);
        #1;
        upd_valid = 1'b0;
        push_exp();
        @(negedge clk);
        chk("hz_post_b_tk", b_tk, 1'b1);
        drain("hz_post");

        // Performance counters, idle cycles ignore mispredict, then async reset mid-update.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            upd(32'h100 + 32'(4 * i), i[0], 32'h800, (i == 1 || i == 3));
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        upd_mispredict = 1'b1;
        upd_taken = 1'b1;
        upd_pc = 32'h140;
        @(posedge clk);
        @(negedge clk);
        chk("cnt_br", b_br, 32'd5);
        chk("cnt_miss", g_miss, 32'd2);
        chk_state("cnt");
        upd(32'h100, 1'b1, 32'h200, 1'b0);
        upd(32'h100, 1'b1, 32'h200, 1'b0);
        look("pre_arst", 32'h100);
        upd_valid = 1'b1;
        upd_pc = 32'h100;
        upd_taken = 1'b1;
        upd_target = 32'h900;
        upd_mispredict = 1'b1;
        #1;
        rst = 1'b1;
        m_reset();
        #1;
        push_exp();
        drain("arst");
        chk_state("arst");
        upd_valid = 1'b0;
        upd_mispredict = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        look("after_arst", 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
